piso_shr_tx: RTL and testbench

//  Parallel-in serial-out transmitter, the other end of the SIPO/PIPO register path.

---
 rtl/piso_shr_tx.sv | 134 +++++++++++++
 tb/tb_piso_shr_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shr_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word on pi_valid/pi_ready and emits it one bit per shift_en strobe.
// Latency: first bit is on so in the cycle after the accepting edge; each bit then holds until the next shift_en strobe.
// Backpressure: pi_ready is high in IDLE, or during the last bit while shift_en=1. This allows back-to-back words with no gap.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset; also forces pi_ready low while asserted
//   pi        parallel word, sampled only on the accepting edge
//   pi_valid  producer has a word on pi
//   pi_ready  block accepts pi this cycle (depends on state, cnt, shift_en and rst only)
//   shift_en  bit-rate strobe; one bit advances per cycle with shift_en=1
//   so        serial data bit (0 when idle)
//   so_valid  so carries a bit of the current word
//   so_last   so is the final bit of the current word
module piso_shr_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pi,
   input  logic             pi_valid,
   output logic             pi_ready,
   input  logic             shift_en,
   output logic             so,
   output logic             so_valid,
   output logic             so_last
);

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;

   logic at_last;   // the final bit of the word is on so
   logic accept;    // a word is taken from pi at this edge
   logic advance;   // move to the next bit of the same word at this edge

   assign at_last = (state == SHIFT) && (cnt == CNT_LAST);
   assign accept  = pi_valid && pi_ready;
   assign advance = (state == SHIFT) && shift_en && !at_last;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // If a new word is waiting when the last bit leaves, stay in SHIFT.
            // This avoids an idle cycle between words.
            if (at_last && shift_en) begin
               state_nxt = pi_valid ? SHIFT : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Output logic
   // so is taken directly from the shift register. It therefore always
   // reflects registered state and never a value from the same cycle.
   // ---------------------------------------------------------------
   always_comb begin
      pi_ready = 1'b0;
      so       = 1'b0;
      so_valid = 1'b0;
      so_last  = 1'b0;
      case (state)
         IDLE: begin
            pi_ready = !rst;
         end
         SHIFT: begin
            so_valid = 1'b1;
            so       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            so_last  = at_last;
            // Accept the next word only when the last bit is leaving.
            // pi_ready stays low while the last bit is held.
            pi_ready = !rst && at_last && shift_en;
         end
         default: begin
            pi_ready = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath: shift register and bit counter.
   // accept in SHIFT only happens on the last bit. It therefore
   // never coincides with advance.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         shreg <= pi;
         cnt   <= '0;
      end else if (advance) begin
         if (MSB_FIRST) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
         end else begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
         end
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_piso_shr_tx.sv
// Directed testbench for piso_shr_tx at WIDTH=4. Both bit orders run side by side on the same stimulus.
// Inputs are driven 1 time unit after each rising edge, and outputs are checked 1 time unit later.
// Expected bit sequences are written out by hand for every scenario.
module tb_piso_shr_tx;

   logic       clk;
   logic       rst;
   logic [3:0] pi;
   logic       pi_valid;
   logic       shift_en;

   logic       pi_ready_m, so_m, so_valid_m, so_last_m;
   logic       pi_ready_l, so_l, so_valid_l, so_last_l;

   int n_cmp;
   int n_err;

   piso_shr_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
      .clk      (clk),
      .rst      (rst),
      .pi       (pi),
      .pi_valid (pi_valid),
      .pi_ready (pi_ready_m),
      .shift_en (shift_en),
      .so       (so_m),
      .so_valid (so_valid_m),
      .so_last  (so_last_m)
   );

   piso_shr_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk      (clk),
      .rst      (rst),
      .pi       (pi),
      .pi_valid (pi_valid),
      .pi_ready (pi_ready_l),
      .shift_en (shift_en),
      .so       (so_l),
      .so_valid (so_valid_l),
      .so_last  (so_last_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Check both instances in one go.
   // em and el are the expected so values for MSB-first and LSB-first.
   task automatic chk_out(input string tag, input logic em, input logic el,
                          input logic vld, input logic last, input logic rdy);
      chk({tag, " so_m"},   so_m,       em);
      chk({tag, " so_l"},   so_l,       el);
      chk({tag, " vld_m"},  so_valid_m, vld);
      chk({tag, " vld_l"},  so_valid_l, vld);
      chk({tag, " last_m"}, so_last_m,  last);
      chk({tag, " last_l"}, so_last_l,  last);
      chk({tag, " rdy_m"},  pi_ready_m, rdy);
      chk({tag, " rdy_l"},  pi_ready_l, rdy);
   endtask

   initial begin
      logic [3:0] w;
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      pi       = 4'b0000;
      pi_valid = 1'b0;
      shift_en = 1'b0;

      // 1: reset held for two edges
      step;
      chk_out("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step;
      chk_out("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk_out("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 2/3: 1011 with shift_en continuous -> MSB 1,0,1,1 and LSB 1,1,0,1
      pi = 4'b1011; pi_valid = 1'b1; shift_en = 1'b1;
      #1;
      chk_out("t2 acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step;
      pi_valid = 1'b0; pi = 4'b0100;   // changes after accept must not matter
      #1;
      chk_out("t2 b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step;
      chk_out("t2 b2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step;
      chk_out("t2 b3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step;
      chk_out("t2 b4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step;
      chk_out("t2 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 4: 0110 with shift_en every 3rd cycle -> 0,1,1,0 in both orders, each held 3 cycles
      pi = 4'b0110; pi_valid = 1'b1; shift_en = 1'b0;
      #1;
      chk_out("t4 acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step;
      pi_valid = 1'b0;
      w = 4'b0110;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 3; k++) begin
            shift_en = (k == 2);
            #1;
            chk_out($sformatf("t4 b%0d k%0d", b, k), w[3-b], w[b], 1'b1,
                    (b == 3), ((b == 3) && (k == 2)));
            step;
         end
      end
      shift_en = 1'b0;
      #1;
      chk_out("t4 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 5: back-to-back 1001 then 0111 with no gap
      // MSB: 1,0,0,1,0,1,1,1   LSB: 1,0,0,1,1,1,1,0
      pi = 4'b1001; pi_valid = 1'b1; shift_en = 1'b1;
      #1;
      chk_out("t5 acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step;
      pi = 4'b0111;
      for (int j = 0; j < 8; j++) begin
         w = (j < 4) ? 4'b1001 : 4'b0111;
         #1;
         chk_out($sformatf("t5 bit%0d", j + 1), w[3-(j%4)], w[j%4], 1'b1,
                 ((j % 4) == 3), ((j % 4) == 3));
         step;
         if (j == 3) begin
            pi_valid = 1'b0;
            pi       = 4'b0000;
         end
      end
      #1;
      chk_out("t5 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 6: reset after the 2nd bit of 1100, then 0011 -> MSB 0,0,1,1 and LSB 1,1,0,0
      pi = 4'b1100; pi_valid = 1'b1; shift_en = 1'b1;
      #1;
      step;
      pi_valid = 1'b0;
      #1;
      chk_out("t6 b1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step;
      chk_out("t6 b2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6 rdy_in_rst_m", pi_ready_m, 1'b0);
      chk("t6 rdy_in_rst_l", pi_ready_l, 1'b0);
      step;
      rst = 1'b0;
      #1;
      chk_out("t6 after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      pi = 4'b0011; pi_valid = 1'b1;
      #1;
      step;
      pi_valid = 1'b0;
      w = 4'b0011;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk_out($sformatf("t6 w2 b%0d", b), w[3-b], w[b], 1'b1, (b == 3), (b == 3));
         step;
      end
      #1;
      chk_out("t6 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
